// File: rtl/console_rx.sv
// console_rx -- Wishbone-mapped 8N1 UART receiver with a small byte FIFO.
//
// Sits opposite the console transmitter and shares its clock, bus and bit
// timing. Incoming bytes are collected LSB first into a circular FIFO that
// firmware polls through two registers (ADR bit 2 selects):
//   0 DATA   read : {24'h0, head byte}, pops; 32'h0 when empty. Writes ignored.
//   1 STATUS read : bit0 not-empty, bit1 OVR, bit2 FERR, [15:8] count.
//            write: bit1 clears OVR, bit2 clears FERR (a same-cycle set wins).
//
// Ports:
//   wb_clk     core clock, all logic on its rising edge
//   wb_rst     synchronous active-high reset
//   wb_cyc     bus cycle
//   wb_stb     bus strobe
//   wb_we      write enable
//   wb_adr     address, only bit 2 decoded
//   wb_dat_o   write data from master
//   wb_dat_i   registered read data to master
//   wb_ack     one-cycle acknowledge
//   rx         asynchronous serial input, idle high
//   irq        registered (not-empty | OVR | FERR), only with CONSOLE_RX_IRQ_EN
//
// Build option: define CONSOLE_RX_IRQ_EN to add the irq output.
//
// RX FSM
//   state   | meaning
//   S_IDLE  | line idle, waiting for a low level on rxs
//   S_START | half a bit in, confirm the start bit is still low
//   S_DATA  | sample eight data bits at mid-bit, LSB first
//   S_STOP  | sample the stop bit; high pushes the byte, low flags FERR
//   S_BREAK | line held low after a framing error, wait for it to go high

module console_rx #(
   parameter int FREQUENCY       = 25000000,
   parameter int BAUD_RATE       = 115200,
   parameter int BIT_CLOCKS      = FREQUENCY / BAUD_RATE,
   parameter int FIFO_DEPTH_LOG2 = 3
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [31:0] wb_adr,
   input  logic [31:0] wb_dat_o,
   output logic [31:0] wb_dat_i,
   output logic        wb_ack,
   input  logic        rx
`ifdef CONSOLE_RX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int CNT_W = $clog2(BIT_CLOCKS + 1);
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CLOCKS - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CLOCKS / 2 - 1);
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic             rx_meta;
   logic             rxs;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   logic [7:0]                 mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic [FIFO_DEPTH_LOG2:0]   count;
   logic                       ovr;
   logic                       ferr;

   logic        push;
   logic        ferr_set;
   logic        access;
   logic        pop;
   logic        full;
   logic        not_empty;
   logic        do_push;
   logic        ovr_set;
   logic        ovr_clr;
   logic        ferr_clr;
   logic [31:0] status_word;

   logic unused_bits;
   assign unused_bits = ^{wb_adr[31:3], wb_adr[1:0], wb_dat_o[31:3], wb_dat_o[0]};

   // Both flops reset high so a reset never fakes a falling edge.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt     <= HALF_LOAD;
               bit_idx <= '0;
               if (!rxs) state <= S_START;
            end
            S_START: begin
               if (cnt == '0) begin
                  cnt   <= BIT_LOAD;
                  state <= rxs ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == '0) begin
                  shift[bit_idx] <= rxs;
                  bit_idx        <= bit_idx + 1'b1;
                  cnt            <= BIT_LOAD;
                  if (bit_idx == 3'd7) state <= S_STOP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_STOP: begin
               if (cnt == '0) state <= rxs ? S_IDLE : S_BREAK;
               else           cnt   <= cnt - 1'b1;
            end
            S_BREAK: begin
               if (rxs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Stop-bit sample outcome; the FIFO acts on it at the same edge, so
   // not-empty is visible the cycle after the sample.
   always_comb begin
      push     = (state == S_STOP) && (cnt == '0) && rxs;
      ferr_set = (state == S_STOP) && (cnt == '0) && !rxs;
   end

   always_comb begin
      access    = wb_cyc && wb_stb && !wb_ack;
      not_empty = (count != '0);
      full      = (count == DEPTH_CNT);
      pop       = access && !wb_we && !wb_adr[2] && not_empty;
      // A pop in the same cycle frees the slot a full FIFO needs.
      do_push   = push && (!full || pop);
      ovr_set   = push && full && !pop;
      ovr_clr   = access && wb_we && wb_adr[2] && wb_dat_o[1];
      ferr_clr  = access && wb_we && wb_adr[2] && wb_dat_o[2];
      status_word = {16'h0, 8'(count), 5'h0, ferr, ovr, not_empty};
   end

   always_ff @(posedge wb_clk) begin
      if (do_push) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ovr      <= 1'b0;
         ferr     <= 1'b0;
         wb_ack   <= 1'b0;
         wb_dat_i <= '0;
      end else begin
         wb_ack   <= access;
         wb_dat_i <= '0;
         if (access && !wb_we) begin
            if (wb_adr[2])      wb_dat_i <= status_word;
            else if (not_empty) wb_dat_i <= {24'h0, mem[rd_ptr]};
         end
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !pop)      count <= count + 1'b1;
         else if (pop && !do_push) count <= count - 1'b1;
         ovr  <= ovr_set  || (ovr  && !ovr_clr);
         ferr <= ferr_set || (ferr && !ferr_clr);
      end
   end

`ifdef CONSOLE_RX_IRQ_EN
   always_ff @(posedge wb_clk) begin
      if (wb_rst) irq <= 1'b0;
      else        irq <= not_empty || ovr || ferr;
   end
`endif

endmodule
